// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
//
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshakes on both sides.
//
//   Stage 1 : forms B' (B or ~B) and c0, then per-group generate/propagate.
//             Registers A, B', c0, group gout/pout and v1.
//   Stage 2 : resolves group carries from gout/pout, expands the in-group
//             carries, and registers sum, cout, ovf, zero and v2.
//
// Parameters
//   WIDTH : operand/result width (multiple of GRP, minimum 4)
//   GRP   : bits per lookahead group (2, 4 or 8)
//
// Ports
//   clk        : clock, all state on rising edge
//   reset      : synchronous, active-high
//   in_valid   : operand bundle present
//   in_ready   : bundle accepted this cycle (when in_valid and not reset)
//   a, b       : operands
//   cin        : carry-in for add (ignored for subtract)
//   sub        : 0 = A + B + cin, 1 = A - B
//   out_valid  : result bundle valid
//   out_ready  : consumer takes the result this cycle
//   sum        : result
//   cout       : carry out of the MSB (subtract: 1 = no borrow)
//   ovf        : two's-complement overflow
//   zero       : sum is all zeros
// -----------------------------------------------------------------------------
module cla_pipe_adder #(
   parameter int WIDTH = 32,
   parameter int GRP   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NGRP = WIDTH / GRP;

   // ---------------------------------------------------------------------
   // Handshake / advance control
   // ---------------------------------------------------------------------
   logic adv1, adv2, accept;
   logic v1_reg, v2_reg;

   assign adv2     = ~v2_reg | out_ready;
   assign adv1     = ~v1_reg | adv2;
   // in_ready is forced high during reset, but nothing is taken that cycle.
   assign in_ready = reset | adv1;
   assign accept   = in_valid & adv1 & ~reset;

   // ---------------------------------------------------------------------
   // Stage 1 combinational: operand conditioning and group gen/prop
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] bp_next, g1, p1;
   logic             c0_next;
   logic [NGRP-1:0]  ggen_next, gprop_next;

   assign bp_next = sub ? ~b : b;
   // Subtract forces the carry-in to 1 (two's complement of B).
   assign c0_next = sub | cin;
   assign g1      = a & bp_next;
   assign p1      = a ^ bp_next;

   for (genvar gi = 0; gi < NGRP; gi++) begin : g_s1grp
      logic [GRP-1:0] gg, pp;
      logic           gen_grp, prop_grp;

      assign gg = g1[gi*GRP +: GRP];
      assign pp = p1[gi*GRP +: GRP];

      // gout = OR_i (g[i] & p[i+1..GRP-1]); built LSB-up so each later
      // bit's propagate masks everything generated below it.
      always_comb begin
         gen_grp  = 1'b0;
         prop_grp = 1'b1;
         for (int i = 0; i < GRP; i++) begin
            gen_grp  = gg[i] | (pp[i] & gen_grp);
            prop_grp = prop_grp & pp[i];
         end
      end

      assign ggen_next[gi]  = gen_grp;
      assign gprop_next[gi] = prop_grp;
   end

   // ---------------------------------------------------------------------
   // Stage 1 registers
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] a_reg, bp_reg;
   logic             c0_reg;
   logic [NGRP-1:0]  ggen_reg, gprop_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         v1_reg    <= 1'b0;
         a_reg     <= '0;
         bp_reg    <= '0;
         c0_reg    <= 1'b0;
         ggen_reg  <= '0;
         gprop_reg <= '0;
      end else begin
         if (adv1) begin
            v1_reg <= accept;
         end
         if (accept) begin
            a_reg     <= a;
            bp_reg    <= bp_next;
            c0_reg    <= c0_next;
            ggen_reg  <= ggen_next;
            gprop_reg <= gprop_next;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2 combinational: group carries, in-group carries, flags
   // ---------------------------------------------------------------------
   logic [NGRP:0]    gc;        // gc[k] = carry into group k
   logic [WIDTH-1:0] p2, sum_next;
   logic             c_msb;     // carry into bit WIDTH-1
   logic             ovf_next, zero_next;

   assign p2 = a_reg ^ bp_reg;

   // Group carries come only from the registered gout/pout and the previous
   // group carry, so no bit-level ripple crosses a group boundary.
   always_comb begin
      gc[0] = c0_reg;
      for (int k = 0; k < NGRP; k++) begin
         gc[k+1] = ggen_reg[k] | (gprop_reg[k] & gc[k]);
      end
   end

   for (genvar gi = 0; gi < NGRP; gi++) begin : g_s2grp
      logic [GRP-1:0] c;   // carry into each bit of this group

      always_comb begin
         c[0] = gc[gi];
         for (int i = 1; i < GRP; i++) begin
            c[i] = (a_reg[gi*GRP+i-1] & bp_reg[gi*GRP+i-1])
                 | (p2[gi*GRP+i-1] & c[i-1]);
         end
      end

      assign sum_next[gi*GRP +: GRP] = p2[gi*GRP +: GRP] ^ c;

      if (gi == NGRP-1) begin : g_msb
         assign c_msb = c[GRP-1];
      end
   end

   assign ovf_next  = c_msb ^ gc[NGRP];
   assign zero_next = ~|sum_next;

   // ---------------------------------------------------------------------
   // Stage 2 registers
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] sum_reg;
   logic             cout_reg, ovf_reg, zero_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         v2_reg   <= 1'b0;
         sum_reg  <= '0;
         cout_reg <= 1'b0;
         ovf_reg  <= 1'b0;
         zero_reg <= 1'b0;
      end else if (adv2) begin
         v2_reg <= v1_reg;
         // Data only loads on a real transfer; a bubble leaves it untouched.
         if (v1_reg) begin
            sum_reg  <= sum_next;
            cout_reg <= gc[NGRP];
            ovf_reg  <= ovf_next;
            zero_reg <= zero_next;
         end
      end
   end

   assign out_valid = v2_reg;
   assign sum       = sum_reg;
   assign cout      = cout_reg;
   assign ovf       = ovf_reg;
   assign zero      = zero_reg;

endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; legal values are multiples of GRP, minimum 4.
REQ-002 SHALL have parameter GRP, default 4: bits per lookahead group; legal values 2, 4 or 8.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: operand bundle present this cycle.
REQ-006 SHALL have port in_ready, output, 1: block accepts the bundle this cycle.
REQ-007 SHALL have port a, input, WIDTH: operand A.
REQ-008 SHALL have port b, input, WIDTH: operand B.
REQ-009 SHALL have port cin, input, 1: carry-in, used only when sub=0.
REQ-010 SHALL have port sub, input, 1: 0 selects add, 1 selects subtract (A-B).
REQ-011 SHALL have port out_valid, output, 1: result bundle valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result this cycle.
REQ-013 SHALL have port sum, output, WIDTH: result.
REQ-014 SHALL have port cout, output, 1: carry out of bit WIDTH-1; for subtract, 1 means no borrow.
REQ-015 SHALL have port ovf, output, 1: two's-complement overflow.
REQ-016 SHALL have port zero, output, 1: high when sum is all zeros.

Function
REQ-017 SHALL compute sum = A + B' + c0 mod 2^WIDTH.
- add: B'=B, c0=cin.
- subtract: B'=~B, c0=1, cin ignored.
REQ-018 SHALL compute per-bit g=A&B' and p=A^B'; per group, gout = OR over i of (g[i] AND all p above i), pout = AND of all p in the group.
REQ-019 SHALL derive each group carry-in from the previous group's gout/pout and carry; no ripple across group boundaries.
REQ-020 SHALL set ovf = carry into bit WIDTH-1 XOR cout, and zero = (sum==0).
REQ-021 SHALL be a two-stage pipeline.
- Stage 1 registers: A, B', c0, group gout/pout, valid v1.
- Stage 2 registers: sum, cout, ovf, zero, valid v2.
- Latency: exactly 2 cycles from acceptance to out_valid with no backpressure.
REQ-022 SHALL advance stage 2 when adv2 = !v2 | out_ready.
REQ-023 SHALL advance stage 1 when adv1 = !v1 | adv2; in_ready SHALL equal adv1 combinationally.
REQ-024 SHALL accept a bundle only on in_valid & in_ready.
REQ-025 SHALL sustain one result per cycle while out_ready stays high.
REQ-026 SHALL hold sum/cout/ovf/zero/out_valid stable while out_valid=1 and out_ready=0.
REQ-027 SHALL hold stage-1 contents while stalled and SHALL neither drop nor duplicate bundles.
REQ-028 SHALL, when out_ready=0 and both stages are full, deassert in_ready the same cycle.
REQ-029 SHALL, when a result drains while a new bundle is accepted in the same cycle, update both stages, with ordering preserved.
REQ-030 SHALL keep outputs X-free for in_valid=0 cycles; stage registers load only on acceptance or advance.

Reset
REQ-031 SHALL, on reset=1 at a clock edge, clear v1 and v2 and set sum=0, cout=0, ovf=0, zero=0 and out_valid=0.
REQ-032 SHALL discard in-flight bundles when reset is asserted mid-operation; no stale result SHALL appear after reset.
REQ-033 SHALL hold in_ready=1 while reset is asserted, but SHALL accept no bundle in that cycle.
REQ-034 SHALL accept a bundle in the first cycle with reset=0.

Verification
REQ-035 SHALL cover add, with WIDTH=32, GRP=4, out_ready=1: A=0xFFFFFFFF, B=0x00000001, cin=0 -> 2 cycles later sum=0, cout=1, ovf=0, zero=1.
REQ-036 SHALL cover signed overflow and subtract.
- A=0x7FFFFFFF, B=1, add -> sum=0x80000000, ovf=1, cout=0.
- A=5, B=7, sub -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-037 SHALL cover backpressure: 4 back-to-back bundles, with out_ready=0 for cycles 2-5 -> in_ready falls once both stages fill; all 4 results emerge in order, each held stable while stalled.
REQ-038 SHALL cover reset mid-operation: assert reset with v1=v2=1 -> next cycle out_valid=0; the first result after reset belongs to the first post-reset bundle.
REQ-039 SHALL cover a randomized sweep for WIDTH in {8,16,32,64} and GRP in {2,4,8}: 10k bundles with random out_ready -> every result matches a reference model.
REQ-040 SHALL cover cin handling: sub=1 with cin=1 versus cin=0 -> identical results.
